// File: rtl/shiftreg_pkg.sv
// Shared defaults and direction encoding for the shift-register console.
package shiftreg_pkg;

  localparam int unsigned DEF_WIDTH           = 8;
  localparam logic [7:0]  DEF_LOAD_VALUE      = 8'hD3;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 3;
  localparam int unsigned DEF_COUNT_WIDTH     = 8;

  // Debounce counters are sized for the largest legal DEBOUNCE_CYCLES (255).
  localparam int unsigned DB_CNT_WIDTH = 8;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_e;

endpackage

// File: rtl/shiftreg_console_debouncer.sv
// Input conditioner: 2-flop synchroniser, debounce counter, conditioned level
// and single-cycle registered edge pulses.
module input_debouncer
  import shiftreg_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic noisysignal,
  output logic conditioned,
  output logic positiveedge,
  output logic negativeedge
);

  localparam logic [DB_CNT_WIDTH-1:0] CNT_LAST = DB_CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic                    sync1_q, sync1_d;
  logic                    sync2_q, sync2_d;
  logic                    level_q, level_d;
  logic                    pos_q, pos_d;
  logic                    neg_q, neg_d;
  logic [DB_CNT_WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d = noisysignal;
    sync2_d = sync1_q;
    level_d = level_q;
    cnt_d   = cnt_q;
    pos_d   = 1'b0;
    neg_d   = 1'b0;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      // Input has disagreed with the level for DEBOUNCE_CYCLES samples: accept it.
      level_d = sync2_q;
      cnt_d   = '0;
      pos_d   = sync2_q;
      neg_d   = ~sync2_q;
    end else begin
      cnt_d = cnt_q + DB_CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      pos_q   <= 1'b0;
      neg_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      pos_q   <= pos_d;
      neg_q   <= neg_d;
      cnt_q   <= cnt_d;
    end
  end

  assign conditioned  = level_q;
  assign positiveedge = pos_q;
  assign negativeedge = neg_q;

endmodule

// File: rtl/shiftreg_console.sv
// Button/switch driven shift register: load on btn release, shift on sw1 rise,
// serial data from sw0, direction from sw2.
module shiftreg_console
  import shiftreg_pkg::*;
#(
  parameter int unsigned      WIDTH           = DEF_WIDTH,
  parameter logic [WIDTH-1:0] LOAD_VALUE      = WIDTH'(DEF_LOAD_VALUE),
  parameter int unsigned      DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned      COUNT_WIDTH     = DEF_COUNT_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   btn,
  input  logic                   sw0,
  input  logic                   sw1,
  input  logic                   sw2,
  output logic [WIDTH-1:0]       led,
  output logic                   serial_out,
  output logic [COUNT_WIDTH-1:0] shift_count
);

  logic btn_level, btn_pos, btn_neg;
  logic sw0_level, sw0_pos, sw0_neg;
  logic sw1_level, sw1_pos, sw1_neg;
  logic sw2_level, sw2_pos, sw2_neg;

  input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_btn (
    .clk          (clk),
    .reset        (reset),
    .noisysignal  (btn),
    .conditioned  (btn_level),
    .positiveedge (btn_pos),
    .negativeedge (btn_neg)
  );

  input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_sw0 (
    .clk          (clk),
    .reset        (reset),
    .noisysignal  (sw0),
    .conditioned  (sw0_level),
    .positiveedge (sw0_pos),
    .negativeedge (sw0_neg)
  );

  input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_sw1 (
    .clk          (clk),
    .reset        (reset),
    .noisysignal  (sw1),
    .conditioned  (sw1_level),
    .positiveedge (sw1_pos),
    .negativeedge (sw1_neg)
  );

  input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_sw2 (
    .clk          (clk),
    .reset        (reset),
    .noisysignal  (sw2),
    .conditioned  (sw2_level),
    .positiveedge (sw2_pos),
    .negativeedge (sw2_neg)
  );

  logic unused_edges;
  assign unused_edges = ^{btn_level, btn_pos, sw0_pos, sw0_neg,
                          sw1_level, sw1_neg, sw2_pos, sw2_neg};

  logic                   load_pulse;
  logic                   shift_pulse;
  logic                   serial_in;
  dir_e                   dir;
  logic [WIDTH-1:0]       reg_q, reg_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;

  assign load_pulse  = btn_neg;
  assign shift_pulse = sw1_pos;
  assign serial_in   = sw0_level;
  assign dir         = dir_e'(sw2_level);

  // Direction/serial levels are the pre-edge registered values, so a level
  // change landing on the shift edge only affects later shifts.
  always_comb begin
    reg_d   = reg_q;
    count_d = count_q;
    if (load_pulse) begin
      reg_d   = LOAD_VALUE;
      count_d = '0;
    end else if (shift_pulse) begin
      case (dir)
        DIR_LEFT:  reg_d = {reg_q[WIDTH-2:0], serial_in};
        DIR_RIGHT: reg_d = {serial_in, reg_q[WIDTH-1:1]};
      endcase
      count_d = count_q + COUNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      reg_q   <= '0;
      count_q <= '0;
    end else begin
      reg_q   <= reg_d;
      count_q <= count_d;
    end
  end

  assign led         = reg_q;
  assign shift_count = count_q;
  assign serial_out  = (dir == DIR_RIGHT) ? reg_q[0] : reg_q[WIDTH-1];

endmodule
